// File: rtl/ex_mem_reg.sv
// ---------------------------------------------------------------------------
// ex_mem_reg
// EX -> MEM pipeline register of the 5-stage MIPS32 core.
//
// Latches the EX stage results (GPR write-back, HI/LO write-back) each cycle
// and presents them to MEM one cycle later. It also returns the intermediate
// state of the two-cycle MADD/MADDU/MSUB/MSUBU ops (hilo temp + step count)
// to EX while EX is stalled.
//
// Ports
//   clk        core clock, rising edge
//   rst        synchronous active-low reset
//   stall[5:0] pipeline stall vector; bit 3 = EX stalled, bit 4 = MEM stalled
//   flush      (only with EX_MEM_FLUSH_EN) clear everything, below reset
//   ex_*       EX stage results: wd, wreg, wdata, hi, lo, whilo
//   hilo_i     multi-cycle intermediate product from EX
//   cnt_i      multi-cycle step count from EX
//   mem_*      registered copies of ex_* presented to MEM
//   hilo_o     intermediate product returned to EX
//   cnt_o      step count returned to EX
//
// Configuration macro
//   EX_MEM_FLUSH_EN : adds the flush input (listed after stall).
// ---------------------------------------------------------------------------
module ex_mem_reg #(
  parameter int REG_W  = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [5:0]           stall,
`ifdef EX_MEM_FLUSH_EN
  input  logic                 flush,
`endif
  input  logic [ADDR_W-1:0]    ex_wd,
  input  logic                 ex_wreg,
  input  logic [REG_W-1:0]     ex_wdata,
  input  logic [REG_W-1:0]     ex_hi,
  input  logic [REG_W-1:0]     ex_lo,
  input  logic                 ex_whilo,
  input  logic [2*REG_W-1:0]   hilo_i,
  input  logic [CNT_W-1:0]     cnt_i,
  output logic [ADDR_W-1:0]    mem_wd,
  output logic                 mem_wreg,
  output logic [REG_W-1:0]     mem_wdata,
  output logic [REG_W-1:0]     mem_hi,
  output logic [REG_W-1:0]     mem_lo,
  output logic                 mem_whilo,
  output logic [2*REG_W-1:0]   hilo_o,
  output logic [CNT_W-1:0]     cnt_o
);

  logic do_flush;
  logic ex_stalled;
  logic mem_stalled;

`ifdef EX_MEM_FLUSH_EN
  assign do_flush = flush;
`else
  assign do_flush = 1'b0;
`endif

  assign ex_stalled  = stall[3];
  assign mem_stalled = stall[4];

  // Only the EX/MEM boundary bits matter to this register.
  logic unused_stall;
  assign unused_stall = ^{stall[5], stall[2:0]};

  // NOTE: every register here is state updated on the clock edge, so all
  // assignments are non-blocking; blocking ones would create order-dependent
  // simulation races with the neighbouring pipeline stages.
  always_ff @(posedge clk) begin
    if (!rst || do_flush) begin
      mem_wd    <= '0;
      mem_wreg  <= 1'b0;
      mem_wdata <= '0;
      mem_hi    <= '0;
      mem_lo    <= '0;
      mem_whilo <= 1'b0;
      hilo_o    <= '0;
      cnt_o     <= '0;
    end else if (!ex_stalled) begin
      // Advance. A MEM-only stall with EX running never occurs; it falls
      // through here as a normal advance.
      mem_wd    <= ex_wd;
      mem_wreg  <= ex_wreg;
      mem_wdata <= ex_wdata;
      mem_hi    <= ex_hi;
      mem_lo    <= ex_lo;
      mem_whilo <= ex_whilo;
      hilo_o    <= '0;
      cnt_o     <= '0;
    end else if (!mem_stalled) begin
      // Bubble: MEM gets a NOP while EX carries its multi-cycle state over.
      mem_wd    <= '0;
      mem_wreg  <= 1'b0;
      mem_wdata <= '0;
      mem_hi    <= '0;
      mem_lo    <= '0;
      mem_whilo <= 1'b0;
      hilo_o    <= hilo_i;
      cnt_o     <= cnt_i;
    end else begin
      // Hold: MEM keeps its instruction; multi-cycle state still loops back.
      hilo_o    <= hilo_i;
      cnt_o     <= cnt_i;
    end
  end

endmodule
